// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard unit beside decode (stage 0) of the in-order RISC-V pipeline.
//   Keeps a per-register scoreboard of in-flight producers and how old they are.
//   From that it decides each cycle whether the decoded instruction issues or
//   stalls, and which bypass stage feeds each source operand. After a branch
//   redirect it emits a run of flush bubbles and squashes wrong-path entries.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   issue_valid                   decode holds an instruction requesting issue
//   issue_rs1/_used, rs2/_used    source indices and read enables
//   issue_rd/_rd_we/_is_load      destination, write enable, load producer
//   branch_redirect               branch at age BR_AGE redirected this cycle
//   issue_ready                   instruction issues this cycle (comb.)
//   fwd_sel_a/_b                  0 = regfile, k = bypass from stage k (comb.)
//   pc_hold                       hazard stall: hold PC and IF/ID
//   flush                         kill IF/ID contents, insert bubble
//   stall_cycles                  saturating count of hazard-stall cycles

// One scoreboard entry: busy flag, producer kind and age since issue.
module hazard_scoreboard_entry #(
    parameter int AGE_W      = 2,
    parameter int FWD_STAGES = 2,
    parameter int BR_AGE     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,       // producer for this register issues now
    input  logic             alloc_load,  // ... and it is a load
    input  logic             squash,      // branch redirect this cycle
    output logic             busy,
    output logic             is_load,
    output logic [AGE_W-1:0] age
);
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            is_load <= 1'b0;
            age     <= '0;
        end else if (alloc) begin
            // A new allocation beats any squash/retire of the old value.
            busy    <= 1'b1;
            is_load <= alloc_load;
            age     <= AGE_W'(1);
        end else if (busy) begin
            // Retire once the value has passed the last bypass stage: the
            // regfile write happens then and reads see it the next cycle.
            if ((squash && age < AGE_W'(BR_AGE)) || age == AGE_W'(FWD_STAGES)) begin
                busy    <= 1'b0;
                is_load <= 1'b0;
                age     <= '0;
            end else begin
                age <= age + AGE_W'(1);
            end
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 5,
    parameter int FWD_STAGES   = 2,
    parameter int ALU_LAT      = 1,
    parameter int LOAD_LAT     = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int BR_AGE       = 1,
    localparam int FSEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic              issue_rs1_used,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic              issue_rs2_used,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic              issue_rd_we,
    input  logic              issue_is_load,
    input  logic              branch_redirect,
    output logic              issue_ready,
    output logic [FSEL_W-1:0] fwd_sel_a,
    output logic [FSEL_W-1:0] fwd_sel_b,
    output logic              pc_hold,
    output logic              flush,
    output logic [31:0]       stall_cycles
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int AGE_W    = $clog2(FWD_STAGES + 2);
    localparam int CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [0:0] {IDLE, FLUSHING} state_t;

    // ---------------- scoreboard array ----------------
    logic [NUM_REGS-1:0]            busy;
    logic [NUM_REGS-1:0]            ld;
    logic [NUM_REGS-1:0][AGE_W-1:0] age;
    logic                           alloc;

    // x0 is hardwired zero and never has a producer.
    assign busy[0] = 1'b0;
    assign ld[0]   = 1'b0;
    assign age[0]  = '0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
            hazard_scoreboard_entry #(
                .AGE_W     (AGE_W),
                .FWD_STAGES(FWD_STAGES),
                .BR_AGE    (BR_AGE)
            ) u_ent (
                .clk       (clk),
                .rst       (rst),
                .alloc     (alloc && issue_rd == REG_ADDR_W'(r)),
                .alloc_load(issue_is_load),
                .squash    (branch_redirect),
                .busy      (busy[r]),
                .is_load   (ld[r]),
                .age       (age[r])
            );
        end
    endgenerate

    // ---------------- hazard detection ----------------
    logic             hit_a, hit_b, raw_a, raw_b, waw, hz;
    logic [AGE_W-1:0] age_a, age_b, lat_a, lat_b;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             idle, flush_fsm;

    always_comb begin
        age_a = age[issue_rs1];
        age_b = age[issue_rs2];
        lat_a = ld[issue_rs1] ? AGE_W'(LOAD_LAT) : AGE_W'(ALU_LAT);
        lat_b = ld[issue_rs2] ? AGE_W'(LOAD_LAT) : AGE_W'(ALU_LAT);
        hit_a = issue_rs1_used && issue_rs1 != '0 && busy[issue_rs1];
        hit_b = issue_rs2_used && issue_rs2 != '0 && busy[issue_rs2];
        raw_a = hit_a && age_a < lat_a;
        raw_b = hit_b && age_b < lat_b;
        // Holding WAW at any age keeps a single producer per register.
        waw   = issue_rd_we && issue_rd != '0 && busy[issue_rd];
        hz    = issue_valid && (raw_a || raw_b || waw);
    end

    assign idle = (state == IDLE);

    // Outputs are forced to their reset view while rst is high.
    always_comb begin
        if (rst) begin
            issue_ready = issue_valid;
            pc_hold     = 1'b0;
            flush       = 1'b0;
            fwd_sel_a   = '0;
            fwd_sel_b   = '0;
        end else begin
            issue_ready = issue_valid && !hz && idle && !branch_redirect;
            pc_hold     = hz && idle && !branch_redirect;
            flush       = flush_fsm;
            fwd_sel_a   = (hit_a && !raw_a) ? FSEL_W'(age_a) : '0;
            fwd_sel_b   = (hit_b && !raw_b) ? FSEL_W'(age_b) : '0;
        end
    end

    assign alloc = !rst && issue_ready && issue_rd_we && issue_rd != '0;

    // ---------------- flush sequencer ----------------
    // The redirect cycle itself is the first bubble; cnt counts the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flush_fsm = 1'b0;
        if (branch_redirect) begin
            flush_fsm = 1'b1;
            cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
            state_nxt = (FLUSH_CYCLES > 1) ? FLUSHING : IDLE;
        end else if (state == FLUSHING) begin
            flush_fsm = 1'b1;
            if (cnt <= CNT_W'(1)) begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    // ---------------- stall statistics ----------------
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (pc_hold && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    localparam int RW = 5, NR = 32, FWD = 2, ALU_L = 1, LD_L = 2, FLC = 2, BRA = 1;

    logic       clk = 1'b0;
    logic       rst, issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_we;
    logic       issue_is_load, branch_redirect;
    logic [4:0] issue_rs1, issue_rs2, issue_rd;
    logic       issue_ready, pc_hold, flush;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
        .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load),
        .branch_redirect(branch_redirect), .issue_ready(issue_ready),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .pc_hold(pc_hold),
        .flush(flush), .stall_cycles(stall_cycles)
    );

    typedef struct {
        bit rst, v; int rs1; bit u1; int rs2; bit u2; int rd; bit we, ld, br;
        bit er; int fa, fb; bit eh, ef; longint es;
    } vec_t;

    int checks = 0, errors = 0;

    // Reference model: age per register (0 = idle), bubbles left, stall count.
    int     m_age[NR];
    bit     m_ld[NR];
    int     m_fl;
    longint m_st;

    function automatic vec_t row(bit rst_i, bit v, int rs1, bit u1, int rs2, bit u2,
                                 int rd, bit we, bit ld, bit br,
                                 bit er, int fa, int fb, bit eh, bit ef, longint es);
        vec_t t;
        t.rst = rst_i; t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.we = we; t.ld = ld; t.br = br;
        t.er = er; t.fa = fa; t.fb = fb; t.eh = eh; t.ef = ef; t.es = es;
        return t;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(int r);
        return m_ld[r] ? LD_L : ALU_L;
    endfunction

    task automatic model_eval(input vec_t t, output vec_t e);
        bit hit1, hit2, raw1, raw2, waw, hz, open;
        e = t;
        e.es = m_st;
        if (t.rst) begin
            e.er = t.v; e.fa = 0; e.fb = 0; e.eh = 0; e.ef = 0;
            return;
        end
        hit1 = t.u1 && t.rs1 != 0 && m_age[t.rs1] > 0;
        hit2 = t.u2 && t.rs2 != 0 && m_age[t.rs2] > 0;
        raw1 = hit1 && m_age[t.rs1] < lat_of(t.rs1);
        raw2 = hit2 && m_age[t.rs2] < lat_of(t.rs2);
        waw  = t.we && t.rd != 0 && m_age[t.rd] > 0;
        hz   = t.v && (raw1 || raw2 || waw);
        open = (m_fl == 0) && !t.br;
        e.er = t.v && !hz && open;
        e.eh = hz && open;
        e.ef = t.br || m_fl > 0;
        e.fa = (hit1 && !raw1) ? m_age[t.rs1] : 0;
        e.fb = (hit2 && !raw2) ? m_age[t.rs2] : 0;
    endtask

    task automatic model_update(input vec_t t, input vec_t e);
        if (t.rst) begin
            foreach (m_age[r]) begin m_age[r] = 0; m_ld[r] = 0; end
            m_fl = 0; m_st = 0;
            return;
        end
        foreach (m_age[r])
            if (m_age[r] > 0) begin
                if ((t.br && m_age[r] < BRA) || m_age[r] == FWD) m_age[r] = 0;
                else m_age[r]++;
            end
        if (e.er && t.we && t.rd != 0) begin m_age[t.rd] = 1; m_ld[t.rd] = t.ld; end
        if (t.br) m_fl = FLC - 1;
        else if (m_fl > 0) m_fl--;
        if (e.eh && m_st < 64'hFFFF_FFFF) m_st++;
    endtask

    // Drive one cycle, compare at negedge, then advance the model and clock.
    task automatic step(input vec_t t, input bit use_tbl);
        vec_t m, x;
        rst = t.rst; issue_valid = t.v;
        issue_rs1 = 5'(t.rs1); issue_rs1_used = t.u1;
        issue_rs2 = 5'(t.rs2); issue_rs2_used = t.u2;
        issue_rd = 5'(t.rd); issue_rd_we = t.we; issue_is_load = t.ld;
        branch_redirect = t.br;
        @(negedge clk);
        model_eval(t, m);
        x = use_tbl ? t : m;
        check("issue_ready", issue_ready, x.er);
        check("fwd_sel_a", fwd_sel_a, x.fa);
        check("fwd_sel_b", fwd_sel_b, x.fb);
        check("pc_hold", pc_hold, x.eh);
        check("flush", flush, x.ef);
        check("stall_cycles", stall_cycles, x.es);
        model_update(t, m);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        vec_t r;
        foreach (m_age[i]) begin m_age[i] = 0; m_ld[i] = 0; end
        m_fl = 0; m_st = 0;

        //            rst v rs1 u1 rs2 u2 rd we ld br   rdy fa fb hold fl stall
        tbl.push_back(row(1,1, 5,1, 5,1, 5,1,0,0,  1,0,0,0,0,0));   // reset view
        // ALU producer forwarded next cycle from stage 1
        tbl.push_back(row(0,1, 0,0, 0,0, 5,1,0,0,  1,0,0,0,0,0));
        tbl.push_back(row(0,1, 5,1, 5,1, 6,1,0,0,  1,1,1,0,0,0));
        repeat (3) tbl.push_back(row(0,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,0,0));
        // load-use: one stall, then bypass from stage 2
        tbl.push_back(row(0,1, 0,0, 0,0, 5,1,1,0,  1,0,0,0,0,0));
        tbl.push_back(row(0,1, 5,1, 0,1, 6,1,0,0,  0,0,0,1,0,0));
        tbl.push_back(row(0,1, 5,1, 0,1, 6,1,0,0,  1,2,0,0,0,1));
        repeat (2) tbl.push_back(row(0,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,0,1));
        // producer retired before the consumer reads: regfile path
        tbl.push_back(row(0,1, 0,0, 0,0, 5,1,0,0,  1,0,0,0,0,1));
        repeat (2) tbl.push_back(row(0,1, 0,0, 0,0, 0,0,0,0,  1,0,0,0,0,1));
        tbl.push_back(row(0,1, 5,1, 0,0, 7,1,0,0,  1,0,0,0,0,1));
        repeat (2) tbl.push_back(row(0,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,0,1));
        // x0 is never busy
        tbl.push_back(row(0,1, 0,1, 0,1, 0,1,0,0,  1,0,0,0,0,1));
        tbl.push_back(row(0,1, 0,1, 0,1, 0,1,1,0,  1,0,0,0,0,1));
        // WAW holds while the older write is in flight at any age
        tbl.push_back(row(0,1, 0,0, 0,0, 5,1,0,0,  1,0,0,0,0,1));
        tbl.push_back(row(0,1, 0,0, 0,0, 5,1,0,0,  0,0,0,1,0,1));
        tbl.push_back(row(0,1, 0,0, 0,0, 5,1,0,0,  0,0,0,1,0,2));
        tbl.push_back(row(0,1, 0,0, 0,0, 5,1,0,0,  1,0,0,0,0,3));
        repeat (2) tbl.push_back(row(0,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,0,3));
        // ALU value from stage 2 on rs2
        tbl.push_back(row(0,1, 0,0, 0,0, 3,1,0,0,  1,0,0,0,0,3));
        tbl.push_back(row(0,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,0,3));
        tbl.push_back(row(0,1, 0,0, 3,1, 4,1,0,0,  1,0,2,0,0,3));
        repeat (2) tbl.push_back(row(0,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,0,3));
        // redirect: two bubbles, older entry survives, then back to issue
        tbl.push_back(row(0,1, 0,0, 0,0, 5,1,0,0,  1,0,0,0,0,3));
        tbl.push_back(row(0,1, 5,1, 0,0, 6,1,0,1,  0,1,0,0,1,3));
        tbl.push_back(row(0,1, 5,1, 0,0, 6,1,0,0,  0,2,0,0,1,3));
        tbl.push_back(row(0,1, 5,1, 0,0, 6,1,0,0,  1,0,0,0,0,3));
        repeat (2) tbl.push_back(row(0,0, 0,0, 0,0, 0,0,0,0,  0,0,0,0,0,3));
        // reset in the middle of a flush
        tbl.push_back(row(0,0, 0,0, 0,0, 0,0,0,1,  0,0,0,0,1,3));
        tbl.push_back(row(1,1, 0,0, 0,0, 0,0,0,0,  1,0,0,0,0,3));
        tbl.push_back(row(0,1, 0,0, 0,0, 0,0,0,0,  1,0,0,0,0,0));

        r = row(1,0, 0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0);
        rst = 1'b1; issue_valid = 1'b0; issue_rs1 = '0; issue_rs1_used = 1'b0;
        issue_rs2 = '0; issue_rs2_used = 1'b0; issue_rd = '0; issue_rd_we = 1'b0;
        issue_is_load = 1'b0; branch_redirect = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

        // reset in the middle of a load-use stall drops the pending producer
        step(row(0,1, 0,0, 0,0, 9,1,1,0,  1,0,0,0,0,0), 1'b1);
        step(row(0,1, 9,1, 0,0,10,1,0,0,  0,0,0,1,0,0), 1'b1);
        step(row(1,1, 9,1, 0,0,10,1,0,0,  1,0,0,0,0,1), 1'b1);
        step(row(0,1, 9,1, 0,0,10,1,0,0,  1,0,0,0,0,0), 1'b1);

        // randomized traffic on a small register window against the model
        for (int i = 0; i < 3000; i++) begin
            r.rst = ($urandom_range(0, 199) == 0);
            r.v   = ($urandom_range(0, 9) < 8);
            r.rs1 = $urandom_range(0, 7); r.u1 = $urandom_range(0, 1);
            r.rs2 = $urandom_range(0, 7); r.u2 = $urandom_range(0, 1);
            r.rd  = $urandom_range(0, 7); r.we = ($urandom_range(0, 3) != 0);
            r.ld  = ($urandom_range(0, 9) < 3);
            r.br  = ($urandom_range(0, 19) == 0);
            step(r, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
